// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage driving the IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds FetchCount/BubbleCount outputs.
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemRData,
    output logic [31:0] PCOut,
    output logic [31:0] InstrOut,
    output logic        ValidOut
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUF  = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic [31:0] pcout_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic [31:0] buf_q;
    logic [31:0] pend_q;

    logic [31:0] target_d;
    logic [31:0] pc_inc_d;

    assign target_d = BranchTarget & ~32'h0000_0003;
    assign pc_inc_d = pc_q + 32'd4;

    assign IMemReq  = (state_q == REQ) || (state_q == DROP);
    assign IMemAddr = addr_q;
    assign PCOut    = pcout_q;
    assign InstrOut = instr_q;
    assign ValidOut = valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            pcout_q <= 32'd0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            buf_q   <= 32'd0;
            pend_q  <= 32'd0;
        end else if (BranchTaken) begin
            // Redirect wins over Stall: bubble now, refetch from the target.
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            if (state_q == REQ && !IMemReady) begin
                pend_q  <= target_d;
                state_q <= DROP;
            end else if (state_q == DROP && !IMemReady) begin
                pend_q  <= target_d;
            end else begin
                pc_q    <= target_d;
                addr_q  <= target_d;
                state_q <= REQ;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    addr_q  <= pc_q;
                    state_q <= REQ;
                end
                REQ: begin
                    if (IMemReady) begin
                        if (Stall) begin
                            buf_q   <= IMemRData;
                            state_q <= BUF;
                        end else begin
                            pcout_q <= pc_q;
                            instr_q <= IMemRData;
                            valid_q <= 1'b1;
                            pc_q    <= pc_inc_d;
                            addr_q  <= pc_inc_d;
                        end
                    end else if (!Stall) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                end
                BUF: begin
                    if (!Stall) begin
                        pcout_q <= pc_q;
                        instr_q <= buf_q;
                        valid_q <= 1'b1;
                        pc_q    <= pc_inc_d;
                        addr_q  <= pc_inc_d;
                        state_q <= REQ;
                    end
                end
                default: begin
                    // DROP: let the in-flight request finish, then go to the saved target.
                    if (!Stall) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                    if (IMemReady) begin
                        pc_q    <= pend_q;
                        addr_q  <= pend_q;
                        state_q <= REQ;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        fetch_load;
    logic        bubble_load;
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_comb begin
        fetch_load  = !BranchTaken && !Stall &&
                      (((state_q == REQ) && IMemReady) || (state_q == BUF));
        bubble_load = BranchTaken ||
                      (!Stall && (((state_q == REQ) && !IMemReady) || (state_q == DROP)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            if (fetch_load) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (bubble_load) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign FetchCount  = fetch_cnt_q;
    assign BubbleCount = bubble_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed test of fetch_unit plus reset and wrap sequences.
`default_nettype none

module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall, BranchTaken, IMemReady;
    logic [31:0] BranchTarget;
    logic        IMemReq;
    logic [31:0] IMemAddr, IMemRData, PCOut, InstrOut;
    logic        ValidOut;

    logic        IMemReq2, ValidOut2;
    logic [31:0] IMemAddr2, IMemRData2, PCOut2, InstrOut2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount, BubbleCount, FetchCount2, BubbleCount2;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] M(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign IMemRData  = M(IMemAddr);
    assign IMemRData2 = M(IMemAddr2);

    fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemReady(IMemReady), .IMemRData(IMemRData), .PCOut(PCOut),
        .InstrOut(InstrOut), .ValidOut(ValidOut)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCount(FetchCount), .BubbleCount(BubbleCount)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut2 (
        .clk(clk), .reset(reset), .Stall(1'b0), .BranchTaken(1'b0),
        .BranchTarget(32'd0), .IMemReq(IMemReq2), .IMemAddr(IMemAddr2),
        .IMemReady(1'b1), .IMemRData(IMemRData2), .PCOut(PCOut2),
        .InstrOut(InstrOut2), .ValidOut(ValidOut2)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCount(FetchCount2), .BubbleCount(BubbleCount2)
`endif
    );

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic b, input logic [31:0] t, input logic r,
                       input logic q, input logic [31:0] a, input logic [31:0] p,
                       input logic [31:0] i, input logic v);
        vec_t x;
        x.stall = s; x.br = b; x.tgt = t; x.rdy = r;
        x.exp_req = q; x.exp_addr = a; x.exp_pc = p; x.exp_instr = i; x.exp_valid = v;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_if(input string tag, input logic q, input logic [31:0] a,
                          input logic [31:0] p, input logic [31:0] i, input logic v);
        chk({tag, ".IMemReq"},  {31'd0, IMemReq},  {31'd0, q});
        chk({tag, ".IMemAddr"}, IMemAddr, a);
        chk({tag, ".PCOut"},    PCOut,    p);
        chk({tag, ".InstrOut"}, InstrOut, i);
        chk({tag, ".ValidOut"}, {31'd0, ValidOut}, {31'd0, v});
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'd0; IMemReady = 1'b0;

        // zero-wait start, then a 4-cycle stall while the word at 8 returns
        add(0,0,32'h0,1, 1,32'h0,  32'h0, NOP,  0);
        add(0,0,32'h0,1, 1,32'h4,  32'h0, M(0), 1);
        add(0,0,32'h0,1, 1,32'h8,  32'h4, M(4), 1);
        add(1,0,32'h0,1, 0,32'h8,  32'h4, M(4), 1);
        add(1,0,32'h0,0, 0,32'h8,  32'h4, M(4), 1);
        add(1,0,32'h0,0, 0,32'h8,  32'h4, M(4), 1);
        add(1,0,32'h0,0, 0,32'h8,  32'h4, M(4), 1);
        add(0,0,32'h0,0, 1,32'hC,  32'h8, M(8), 1);
        // wait states produce bubbles
        add(0,0,32'h0,0, 1,32'hC,  32'h8, NOP,  0);
        add(0,0,32'h0,0, 1,32'hC,  32'h8, NOP,  0);
        add(0,0,32'h0,1, 1,32'h10, 32'hC, M(12),1);
        // branch while request at 0x10 pending
        add(0,1,32'h100,0, 1,32'h10, 32'hC, NOP, 0);
        add(0,0,32'h0,  0, 1,32'h10, 32'hC, NOP, 0);
        add(0,0,32'h0,  1, 1,32'h100,32'hC, NOP, 0);
        add(0,0,32'h0,  1, 1,32'h104,32'h100, M(32'h100), 1);
        // branch overrides stall, low target bits forced to zero
        add(1,1,32'h203,1, 1,32'h200,32'h100, NOP, 0);
        add(0,0,32'h0,  1, 1,32'h204,32'h200, M(32'h200), 1);
        // second branch in DROP overwrites pending target
        add(0,1,32'h300,0, 1,32'h204,32'h200, NOP, 0);
        add(0,1,32'h400,0, 1,32'h204,32'h200, NOP, 0);
        add(0,0,32'h0,  1, 1,32'h400,32'h200, NOP, 0);
        add(0,0,32'h0,  1, 1,32'h404,32'h400, M(32'h400), 1);
        // stall with no data holds; then branch out of BUF
        add(1,0,32'h0,  0, 1,32'h404,32'h400, M(32'h400), 1);
        add(0,0,32'h0,  1, 1,32'h408,32'h404, M(32'h404), 1);
        add(1,0,32'h0,  1, 0,32'h408,32'h404, M(32'h404), 1);
        add(1,1,32'h500,0, 1,32'h500,32'h404, NOP, 0);
        add(0,0,32'h0,  1, 1,32'h504,32'h500, M(32'h500), 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_if("reset", 1'b0, 32'h0, 32'h0, NOP, 1'b0);
        chk("reset.dut2.IMemAddr", IMemAddr2, 32'hFFFF_FFFC);
        reset = 1'b0;

        foreach (vecs[k]) begin
            if (k != 0) @(negedge clk);
            Stall = vecs[k].stall; BranchTaken = vecs[k].br;
            BranchTarget = vecs[k].tgt; IMemReady = vecs[k].rdy;
            @(posedge clk); #1;
            chk_if($sformatf("row%0d", k), vecs[k].exp_req, vecs[k].exp_addr,
                   vecs[k].exp_pc, vecs[k].exp_instr, vecs[k].exp_valid);
            if (k == 1) begin
                chk("wrap.PCOut0",    PCOut2,    32'hFFFF_FFFC);
                chk("wrap.InstrOut0", InstrOut2, M(32'hFFFF_FFFC));
                chk("wrap.ValidOut0", {31'd0, ValidOut2}, 32'd1);
            end
            if (k == 2) begin
                chk("wrap.PCOut1", PCOut2, 32'h0000_0000);
`ifdef FETCH_PERF_CNT_EN
                chk("wrap.FetchCount",  FetchCount2,  32'd2);
                chk("wrap.BubbleCount", BubbleCount2, 32'd0);
`endif
            end
        end
`ifdef FETCH_PERF_CNT_EN
        chk("FetchCount",  FetchCount,  32'd9);
        chk("BubbleCount", BubbleCount, 32'd10);
`endif

        // asynchronous reset in the middle of an outstanding request
        @(negedge clk);
        Stall = 1'b0; BranchTaken = 1'b0; IMemReady = 1'b0;
        #2 reset = 1'b1;
        #1 chk_if("async_reset", 1'b0, 32'h0, 32'h0, NOP, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("async_reset.FetchCount", FetchCount, 32'd0);
`endif
        @(negedge clk);
        IMemReady = 1'b1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk_if("late_ready", 1'b1, 32'h0, 32'h0, NOP, 1'b0);
        @(posedge clk); #1;
        chk_if("refetch", 1'b1, 32'h4, 32'h0, M(0), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word driven on InstrOut for a bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Stall  input  1  decode stage cannot accept; hold IF/ID outputs.
REQ-006 BranchTaken  input  1  one-cycle redirect request from a later stage.
REQ-007 BranchTarget  input  32  redirect address; bits [1:0] ignored and forced to 00.
REQ-008 IMemReq  output  1  instruction memory request valid.
REQ-009 IMemAddr  output  32  registered request address; stable while IMemReq=1 until IMemReady.
REQ-010 IMemReady  input  1  IMemRData valid this cycle; completes the outstanding request.
REQ-011 IMemRData  input  32  instruction word.
REQ-012 PCOut  output  32  IF/ID register: PC of InstrOut; feeds decode PCIn.
REQ-013 InstrOut  output  32  IF/ID register: instruction; feeds decode InstrIn.
REQ-014 ValidOut  output  1  IF/ID register: InstrOut is a real instruction.

Function
REQ-015 States: IDLE, REQ, BUF, DROP; IMemReq=1 only in REQ and DROP.
REQ-016 IDLE -> REQ unconditionally after one cycle.
REQ-017 REQ, IMemReady=1, Stall=0, BranchTaken=0: IF/ID <= {PC, IMemRData, 1}; PC <= PC+4; stay REQ; next request issues the following cycle (1 instr/cycle with zero-wait memory).
REQ-018 REQ, IMemReady=0, Stall=0: IF/ID <= bubble {PCOut unchanged, NOP_INSTR, 0}.
REQ-019 Stall=1 without BranchTaken: PCOut, InstrOut, ValidOut hold.
REQ-020 REQ, IMemReady=1, Stall=1: word captured in a one-entry buffer; PC unchanged; -> BUF.
REQ-021 BUF, Stall=0: IF/ID <= {PC, buffer, 1}; PC <= PC+4; -> REQ.
REQ-022 BranchTaken overrides Stall: IF/ID <= bubble in the same edge, in every state.
REQ-023 BranchTaken in REQ with IMemReady=1, or in BUF/IDLE: returned/buffered word discarded; PC <= target; -> REQ.
REQ-024 BranchTaken in REQ with IMemReady=0: target saved to pending PC; -> DROP; IMemAddr unchanged (no request abort).
REQ-025 DROP: wait IMemReady, discard word, PC <= pending PC, -> REQ; a further BranchTaken in DROP overwrites pending PC.
REQ-026 PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-027 IMemAddr <= PC whenever a new request begins (entering REQ).

Reset
REQ-028 While reset=1, immediately and independent of clk: state=IDLE, PC=RESET_PC, IMemAddr=RESET_PC, IMemReq=0, PCOut=0, InstrOut=NOP_INSTR, ValidOut=0, buffer and pending PC cleared.
REQ-029 Reset mid-request abandons the outstanding request; a late IMemReady after reset is ignored until a new request starts.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: outputs FetchCount[31:0] (increments when ValidOut is loaded with 1) and BubbleCount[31:0] (increments when a bubble is loaded), both reset to 0, wrap at 2^32.
REQ-031 Macro undefined: these ports and counters do not exist; all other behaviour identical.

Verification
REQ-032 RESET_PC=0, IMemReady held 1: IMemAddr 0,4,8 on successive cycles; ValidOut=1 with PCOut=0 after 2nd rising edge post-reset, then PCOut 4, 8.
REQ-033 IMemReady asserted 3 cycles after request at addr 0: ValidOut=0, InstrOut=NOP_INSTR for 3 cycles, then PCOut=0 with returned word.
REQ-034 Stall=1 for 4 cycles while word at addr 8 returns: IMemReq drops, IF/ID holds; 1 cycle after Stall falls PCOut=8, ValidOut=1.
REQ-035 BranchTaken, target 32'h100, while request at 0x10 pending (ready 2 cycles later): ValidOut=0, word for 0x10 never appears, next IMemAddr=0x100.
REQ-036 RESET_PC=32'hFFFF_FFFC, zero-wait memory: PCOut FFFF_FFFC then 0000_0000; with FETCH_PERF_CNT_EN, FetchCount=2 and BubbleCount=0 at that point.
